// File: rtl/sample_3.sv
// sample_3: registered four-input Boolean function evaluator.
//
// The inputs A..D form a 4-bit minterm index {A,B,C,D} with A as the MSB.
// On every qualified clock edge the index selects one bit of a 16-entry
// truth table, and that bit is registered onto F. The table resets to
// TT_RESET (F = A'.D + B.C') and can be reloaded at run time. A coverage
// register remembers which minterms have been evaluated since the last
// reset or clear.
//
// Ports:
//   clk       rising-edge clock for all state
//   rst_n     synchronous active-low reset
//   F         registered function result (holds while in_valid is low)
//   A,B,C,D   function inputs, index bits 3..0
//   in_valid  qualifies A..D for evaluation
//   out_valid F holds a result from the previous edge's valid sample
//   tt_we     truth-table write enable
//   tt_data   replacement truth table
//   tt        current truth table
//   cov_clr   clears the coverage register
//   cov       bit i set once minterm i has been evaluated
module sample_3 #(
    parameter logic [15:0] TT_RESET = 16'h30BA
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        F,
    input  logic        A,
    input  logic        B,
    input  logic        C,
    input  logic        D,
    input  logic        in_valid,
    output logic        out_valid,
    input  logic        tt_we,
    input  logic [15:0] tt_data,
    output logic [15:0] tt,
    input  logic        cov_clr,
    output logic [15:0] cov
);

    localparam int unsigned IDX_W      = 4;
    localparam int unsigned N_MINTERMS = 16;

    logic [IDX_W-1:0]      idx;
    logic [N_MINTERMS-1:0] idx_onehot;
    logic [N_MINTERMS-1:0] cov_next;

    // Minterm index of the current sample.
    assign idx = {A, B, C, D};

    assign idx_onehot = N_MINTERMS'(1) << idx;

    // Clear wins over history, but the minterm evaluated on the same edge
    // is still recorded.
    always_comb begin
        cov_next = cov;
        if (cov_clr) begin
            cov_next = '0;
        end
        if (in_valid) begin
            cov_next = cov_next | idx_onehot;
        end
    end

    // State update; evaluation reads the pre-edge table so a same-edge
    // reload only takes effect from the next edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            F         <= 1'b0;
            out_valid <= 1'b0;
            tt        <= TT_RESET;
            cov       <= '0;
        end else begin
            if (in_valid) begin
                F <= tt[idx];
            end
            out_valid <= in_valid;
            if (tt_we) begin
                tt <= tt_data;
            end
            cov <= cov_next;
        end
    end

endmodule

// File: tb/tb_sample_3.sv
module tb_sample_3;

    logic        clk;
    logic        rst_n;
    logic        F;
    logic        A, B, C, D;
    logic        in_valid;
    logic        out_valid;
    logic        tt_we;
    logic [15:0] tt_data;
    logic [15:0] tt;
    logic        cov_clr;
    logic [15:0] cov;

    int vectors;
    int errors;

    // Behavioural reference state: truth table and coverage as bit arrays.
    bit m_tt  [16];
    bit m_cov [16];
    bit m_f;
    bit m_ov;

    localparam logic [15:0] DEFAULT_TT = 16'h30BA;

    sample_3 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .F        (F),
        .A        (A),
        .B        (B),
        .C        (C),
        .D        (D),
        .in_valid (in_valid),
        .out_valid(out_valid),
        .tt_we    (tt_we),
        .tt_data  (tt_data),
        .tt       (tt),
        .cov_clr  (cov_clr),
        .cov      (cov)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] pack16(input bit arr [16]);
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = arr[i];
        return v;
    endfunction

    // Model the effect of one clock edge from the rules of operation.
    task automatic model_edge(input bit r, input bit iv, input int idx,
                              input bit we, input logic [15:0] td, input bit clr);
        if (!r) begin
            m_f  = 0;
            m_ov = 0;
            for (int i = 0; i < 16; i++) begin
                m_tt[i]  = DEFAULT_TT[i];
                m_cov[i] = 0;
            end
        end else begin
            if (iv) m_f = m_tt[idx];
            m_ov = iv;
            if (clr) for (int i = 0; i < 16; i++) m_cov[i] = 0;
            if (iv) m_cov[idx] = 1;
            if (we) for (int i = 0; i < 16; i++) m_tt[i] = td[i];
        end
    endtask

    // Drive one cycle of inputs, clock it, update the model, settle past the edge.
    task automatic apply(input bit r, input bit iv, input int idx,
                         input bit we, input logic [15:0] td, input bit clr);
        logic [3:0] iv4;
        iv4      = 4'(idx);
        rst_n    = r;
        in_valid = iv;
        {A, B, C, D} = iv4;
        tt_we    = we;
        tt_data  = td;
        cov_clr  = clr;
        @(posedge clk);
        model_edge(r, iv, idx, we, td, clr);
        #1;
    endtask

    task automatic test_reset();
        apply(0, 1, 7, 1, 16'hFFFF, 1);
        apply(0, 0, 0, 0, 16'h0, 0);
        vectors++;
        if (F !== 1'b0) begin errors++; $display("FAIL reset_F got=%b exp=0", F); end
        vectors++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        vectors++;
        if (tt !== 16'h30BA) begin errors++; $display("FAIL reset_tt got=%h exp=30ba", tt); end
        vectors++;
        if (cov !== 16'h0000) begin errors++; $display("FAIL reset_cov got=%h exp=0000", cov); end
    endtask

    task automatic test_sweep();
        logic [15:0] exp_seq;
        exp_seq = 16'b0011_0000_1011_1010;
        for (int i = 0; i < 16; i++) begin
            apply(1, 1, i, 0, 16'h0, 0);
            vectors++;
            if (F !== exp_seq[i] || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL sweep_idx%0d got F=%b ov=%b exp F=%b ov=1", i, F, out_valid, exp_seq[i]);
            end
        end
        vectors++;
        if (cov !== 16'hFFFF) begin errors++; $display("FAIL sweep_cov got=%h exp=ffff", cov); end
    endtask

    task automatic test_tt_reload();
        apply(1, 1, 15, 1, 16'h8000, 0);
        vectors++;
        if (F !== 1'b0 || tt !== 16'h8000) begin
            errors++; $display("FAIL reload_same_edge got F=%b tt=%h exp F=0 tt=8000", F, tt);
        end
        apply(1, 1, 15, 0, 16'h0, 0);
        vectors++;
        if (F !== 1'b1) begin errors++; $display("FAIL reload_next_idx15 got=%b exp=1", F); end
        apply(1, 1, 0, 0, 16'h0, 0);
        vectors++;
        if (F !== 1'b0) begin errors++; $display("FAIL reload_idx0 got=%b exp=0", F); end
    endtask

    task automatic test_hold();
        apply(1, 1, 15, 0, 16'h0, 0);
        for (int i = 0; i < 3; i++) begin
            apply(1, 0, $urandom_range(0, 14), 0, 16'h0, 0);
            vectors++;
            if (F !== 1'b1 || out_valid !== 1'b0) begin
                errors++; $display("FAIL hold_cycle%0d got F=%b ov=%b exp F=1 ov=0", i, F, out_valid);
            end
        end
    endtask

    task automatic test_coverage();
        apply(1, 1, 5, 0, 16'h0, 1);
        vectors++;
        if (cov !== 16'h0020) begin errors++; $display("FAIL cov_clr_same_idx got=%h exp=0020", cov); end
        apply(1, 1, 5, 0, 16'h0, 0);
        vectors++;
        if (cov !== 16'h0020) begin errors++; $display("FAIL cov_repeat_idx got=%h exp=0020", cov); end
        apply(1, 0, 9, 0, 16'h0, 0);
        vectors++;
        if (cov !== 16'h0020) begin errors++; $display("FAIL cov_invalid_ignored got=%h exp=0020", cov); end
    endtask

    task automatic test_reset_mid();
        apply(1, 1, 2, 1, 16'(($urandom() & 32'hFFFF) | 32'h1), 0);
        for (int i = 0; i < 4; i++) apply(1, 1, i, 0, 16'h0, 0);
        apply(0, 1, 3, 1, 16'hFFFF, 0);
        vectors++;
        if (F !== 1'b0 || out_valid !== 1'b0 || tt !== 16'h30BA || cov !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid got F=%b ov=%b tt=%h cov=%h exp F=0 ov=0 tt=30ba cov=0000",
                     F, out_valid, tt, cov);
        end
        apply(1, 1, 1, 0, 16'h0, 0);
        vectors++;
        if (F !== 1'b1 || out_valid !== 1'b1) begin
            errors++; $display("FAIL first_after_reset got F=%b ov=%b exp F=1 ov=1", F, out_valid);
        end
    endtask

    task automatic test_async_changes();
        logic f_before;
        apply(1, 1, 1, 0, 16'h0, 0);
        f_before = F;
        for (int i = 0; i < 3; i++) begin
            {A, B, C, D} = 4'(i * 5 + 2);
            in_valid = ~in_valid;
            #1;
            vectors++;
            if (F !== f_before) begin
                errors++; $display("FAIL async_change%0d got=%b exp=%b", i, F, f_before);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            bit r, iv, we, clr;
            int idx;
            logic [15:0] td;
            r   = ($urandom_range(0, 29) != 0);
            iv  = ($urandom_range(0, 3) != 0);
            we  = ($urandom_range(0, 9) == 0);
            clr = ($urandom_range(0, 19) == 0);
            idx = $urandom_range(0, 15);
            td  = 16'($urandom());
            apply(r, iv, idx, we, td, clr);
            vectors++;
            if (F !== m_f || out_valid !== m_ov || tt !== pack16(m_tt) || cov !== pack16(m_cov)) begin
                errors++;
                $display("FAIL random_%0d got F=%b ov=%b tt=%h cov=%h exp F=%b ov=%b tt=%h cov=%h",
                         n, F, out_valid, tt, cov, m_f, m_ov, pack16(m_tt), pack16(m_cov));
            end
        end
    endtask

    initial begin
        vectors  = 0;
        errors   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        {A, B, C, D} = 4'h0;
        tt_we    = 1'b0;
        tt_data  = 16'h0;
        cov_clr  = 1'b0;
        test_reset();
        test_sweep();
        test_tt_reload();
        test_hold();
        test_coverage();
        test_reset_mid();
        test_async_changes();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
